mem_read_responder: RTL and testbench

//  Avalon-MM slave that answers the fetch unit's word read requests from an on-chip array.

---
 rtl/mem_read_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_read_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// Avalon-MM read responder: pipelined fixed-latency word reads from an on-chip array.
// Define MEM_RESP_ERR_EN to add the response port (SLAVEERROR on out-of-range reads).
module mem_read_responder #(
    parameter int    DATA_W       = 64,
    parameter int    ADDR_W       = 32,
    parameter int    DEPTH        = 16,
    parameter int    READ_LATENCY = 4,
    parameter int    MAX_PENDING  = 4,
    parameter int    INIT_CYCLES  = 8,
    parameter string INIT_FILE    = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
`ifdef MEM_RESP_ERR_EN
    ,
    output logic [1:0]        response
`endif
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int CNT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0]       addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]       addr_d [READ_LATENCY];

    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              rdv_q, rdv_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_rd;
    logic              acc_wr;
    logic              wr_in_range;
    logic              exit_vld;
    logic [ADDR_W-1:0] exit_addr;
    logic              exit_in_range;

    assign waitrequest = (state_q == ST_INIT)
                      || (pending_q == PEND_W'(MAX_PENDING))
                      || (read && write);

    assign acc_rd = read && !waitrequest;
    assign acc_wr = write && !waitrequest;

    assign wr_in_range   = address < ADDR_W'(DEPTH);
    assign exit_vld      = vld_q[READ_LATENCY-1];
    assign exit_addr     = addr_q[READ_LATENCY-1];
    assign exit_in_range = exit_addr < ADDR_W'(DEPTH);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Stage 0 captures the accepted read; the last stage feeds the output register.
    always_comb begin
        vld_d[0]  = acc_rd;
        addr_d[0] = acc_rd ? address : addr_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    always_comb begin
        pending_d = pending_q + PEND_W'(acc_rd) - PEND_W'(exit_vld);
    end

    always_comb begin
        rdv_d      = exit_vld;
        readdata_d = readdata_q;
        if (exit_vld) begin
            readdata_d = exit_in_range ? mem_q[exit_addr[IDX_W-1:0]] : '0;
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic [1:0] resp_q, resp_d;

    always_comb begin
        resp_d = 2'b00;
        if (exit_vld && !exit_in_range) begin
            resp_d = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= 2'b00;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign response = resp_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            pending_q  <= '0;
            vld_q      <= '0;
            rdv_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            vld_q      <= vld_d;
            rdv_q      <= rdv_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // Array has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (acc_wr && wr_in_range) begin
            mem_q[address[IDX_W-1:0]] <= writedata;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder: driver queues expected beats, monitor checks them.
module tb_mem_read_responder;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [63:0] writedata;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [1:0]  response;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   beats = 0;

    localparam logic [63:0] K3  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] K4  = 64'hdead_beef_0000_0004;
    localparam logic [63:0] K5  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] K15 = 64'hf00d_f00d_0000_000f;
    localparam logic [63:0] KX  = 64'hbad0_bad0_bad0_bad0;
    localparam logic [63:0] K6  = 64'h6666_6666_6666_6666;
    localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

    mem_read_responder dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
`ifdef MEM_RESP_ERR_EN
        ,
        .response      (response)
`endif
    );

`ifndef MEM_RESP_ERR_EN
    assign response = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && readdatavalid) begin
            beats++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data %h want no beat", readdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", readdata, e.data);
                check("beat_cycle", 64'(cyc), 64'(e.cyc));
`ifdef MEM_RESP_ERR_EN
                check("beat_resp", 64'(response), 64'(e.resp));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [63:0] d, input logic [63:0] exp_d,
                         input logic [1:0] exp_r, output int stalls);
        bit ok;
        ok = 0;
        stalls = 0;
        read = rd;
        write = wr;
        address = a;
        writedata = d;
        repeat (50) begin
            @(negedge clk);
            if (!waitrequest) begin
                ok = 1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: addr %0d still waiting, want accept", a);
        end else begin
            if (rd) exp_q.push_back('{exp_d, exp_r, cyc + 5});
            @(posedge clk);
            #1;
        end
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [63:0] d);
        int s;
        issue(1'b0, 1'b1, a, d, 64'h0, 2'b00, s);
    endtask

    task automatic rd_word(input logic [31:0] a, input logic [63:0] exp_d,
                           input logic [1:0] exp_r, output int s);
        issue(1'b1, 1'b0, a, 64'h0, exp_d, exp_r, s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (!waitrequest) break;
            n++;
        end
        check(name, 64'(n), 64'd8);
        check("init_ready_low", 64'(waitrequest), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        int b0;
        int st[8];
        int st_exp[8];
        int st2_exp[5];
        st_exp  = '{0, 0, 0, 0, 1, 0, 0, 0};
        st2_exp = '{0, 0, 0, 0, 1};
        rst = 1'b1;
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;

        repeat (3) @(negedge clk);
        check("rst_waitrequest", 64'(waitrequest), 64'd1);
        check("rst_readdatavalid", 64'(readdatavalid), 64'd0);
        check("rst_readdata", readdata, 64'h0);
        check("rst_response", 64'(response), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("init_wait_cycles");

        wr_word(32'd3, K3);
        rd_word(32'd3, K3, 2'b00, s);
        check("raw_stall", 64'(s), 64'd0);
        drain();

        wr_word(32'd4, K4);
        wr_word(32'd5, K5);
        wr_word(32'd15, K15);
        wr_word(32'd20, KX);
        rd_word(32'd20, 64'h0, 2'b10, s);
        rd_word(32'd5, K5, 2'b00, s);
        rd_word(32'd4, K4, 2'b00, s);
        rd_word(32'd15, K15, 2'b00, s);
        rd_word(32'd16, 64'h0, 2'b10, s);
        drain();

        read = 1'b1;
        write = 1'b1;
        address = 32'd4;
        writedata = K6;
        @(negedge clk);
        check("both_waitrequest", 64'(waitrequest), 64'd1);
        @(posedge clk);
        #1;
        write = 1'b0;
        rd_word(32'd4, K4, 2'b00, s);
        check("both_then_read_stall", 64'(s), 64'd0);
        drain();

        rd_word(32'd3, K3, 2'b00, s);
        rd_word(32'd5, K5, 2'b00, s);
        rd_word(32'd15, K15, 2'b00, s);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        b0 = beats;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("reinit_wait_cycles");
        repeat (10) @(posedge clk);
        #1;
        check("no_beats_after_rst", 64'(beats - b0), 64'd0);
        rd_word(32'd3, K3, 2'b00, s);
        drain();

        for (int i = 0; i < 8; i++) wr_word(32'(i), 64'(i) * STEP);
        for (int i = 0; i < 8; i++) begin
            rd_word(32'(i), 64'(i) * STEP, 2'b00, s);
            st[i] = s;
        end
        for (int i = 0; i < 8; i++) check("burst_stall", 64'(st[i]), 64'(st_exp[i]));
        drain();
        for (int i = 0; i < 5; i++) begin
            rd_word(32'(i), 64'(i) * STEP, 2'b00, s);
            st[i] = s;
        end
        for (int i = 0; i < 5; i++) check("reburst_stall", 64'(st[i]), 64'(st2_exp[i]));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
